// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: stage codes, trap causes and constants shared by the sequencer files
package seq_ctrl_pkg;
    localparam int STAGE_WIDTH = 3;
    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_IDLE   = 3'd0,
        STAGE_FETCH  = 3'd1,
        STAGE_DECODE = 3'd2,
        STAGE_EXEC   = 3'd3,
        STAGE_WB     = 3'd4,
        STAGE_HALT   = 3'd5,
        STAGE_TRAP   = 3'd6
    } stage_e;
    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_FETCH_TO = 2'd1,
        TRAP_MISALIGN = 2'd2
    } trap_cause_e;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/seq_ctrl_npc.sv
// seq_ctrl_npc: next-PC selection, BNE-style taken decision and target alignment check
module seq_ctrl_npc
    import seq_ctrl_pkg::*;
(
    input  logic        branch,
    input  logic        jump,
    input  logic        alu_zero,
    input  logic [31:0] pc,
    input  logic [31:0] target_pc,
    output logic [31:0] next_pc,
    output logic        taken,
    output logic        misalign
);
    // misalign reports the raw target alignment; the sequencer qualifies it with taken
    always_comb begin
        taken    = jump | (branch & ~alu_zero);
        next_pc  = taken ? target_pc : pc + PC_STEP;
        misalign = target_pc[1:0] != 2'b00;
    end
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/DECODE/EXEC/WB sequencer owning pc, inst and retire count
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          FETCH_TIMEOUT = 16,
    parameter int          CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [31:0]          imem_addr,
    input  logic                 imem_ack,
    input  logic [31:0]          imem_rdata,
    output logic [31:0]          inst,
    output logic [31:0]          pc,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 reg_wen_dec,
    input  logic                 alu_zero,
    input  logic [31:0]          target_pc,
    output logic                 reg_wen,
    output logic [2:0]           stage,
    input  logic                 halt_req,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instret
);
    localparam int TW = $clog2(FETCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);
    stage_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d, inst_q, inst_d, next_pc;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0] instret_q, instret_d;
    trap_cause_e          cause_q, cause_d;
    logic                 taken, misalign, fetch_ok, fetch_to, wb_bad, wb_ok;
    seq_ctrl_npc u_npc (
        .branch    (branch),
        .jump      (jump),
        .alu_zero  (alu_zero),
        .pc        (pc_q),
        .target_pc (target_pc),
        .next_pc   (next_pc),
        .taken     (taken),
        .misalign  (misalign)
    );
    // event decode shared by next-state, datapath and output logic
    always_comb begin
        fetch_ok = state_q == STAGE_FETCH && imem_ack;
        fetch_to = state_q == STAGE_FETCH && !imem_ack && tmo_q == TO_LAST;
        wb_bad   = state_q == STAGE_WB && taken && misalign;
        wb_ok    = state_q == STAGE_WB && !wb_bad;
    end
    // state register; reset overrides any transition, including an open fetch
    always_ff @(posedge clk) begin
        state_q <= rst ? STAGE_IDLE : state_d;
    end
    // next-state: halt_req only matters in WB and HALT, TRAP is left only by reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            STAGE_IDLE:   state_d = STAGE_FETCH;
            STAGE_FETCH:  state_d = fetch_ok ? STAGE_DECODE : fetch_to ? STAGE_TRAP : STAGE_FETCH;
            STAGE_DECODE: state_d = STAGE_EXEC;
            STAGE_EXEC:   state_d = STAGE_WB;
            STAGE_WB:     state_d = wb_bad ? STAGE_TRAP : halt_req ? STAGE_HALT : STAGE_FETCH;
            STAGE_HALT:   state_d = halt_req ? STAGE_HALT : STAGE_FETCH;
            STAGE_TRAP:   state_d = STAGE_TRAP;
            default:      state_d = STAGE_IDLE;
        endcase
    end
    // datapath next values: each register moves only in its own update cycle
    always_comb begin
        pc_d      = wb_ok ? next_pc : pc_q;
        inst_d    = fetch_ok ? imem_rdata : inst_q;
        instret_d = wb_ok ? instret_q + CNT_WIDTH'(1) : instret_q;
        tmo_d     = (state_q == STAGE_FETCH && !imem_ack && !fetch_to) ? tmo_q + 1'b1 : '0;
        cause_d   = fetch_to ? TRAP_FETCH_TO : wb_bad ? TRAP_MISALIGN : cause_q;
    end
    // datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            inst_q    <= NOP;
            instret_q <= '0;
            tmo_q     <= '0;
            cause_q   <= TRAP_NONE;
        end else begin
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            tmo_q     <= tmo_d;
            cause_q   <= cause_d;
        end
    end
    // outputs: a misaligned taken target suppresses both write-back and retire
    always_comb begin
        stage      = state_q;
        imem_req   = state_q == STAGE_FETCH;
        imem_addr  = pc_q;
        inst       = inst_q;
        pc         = pc_q;
        reg_wen    = wb_ok & reg_wen_dec;
        retire     = wb_ok;
        halted     = state_q == STAGE_HALT;
        trap       = state_q == STAGE_TRAP;
        trap_cause = cause_q;
        instret    = instret_q;
    end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed scenario tests for the seq_ctrl instruction sequencer
module tb_seq_ctrl;
    logic        clk = 0, rst = 1, imem_ack = 0, branch = 0, jump = 0, reg_wen_dec = 0, alu_zero = 0, halt_req = 0;
    logic [31:0] imem_rdata = 0, target_pc = 0;
    logic        imem_req, reg_wen, halted, trap, retire;
    logic [31:0] imem_addr, inst, pc, instret;
    logic [2:0]  stage;
    logic [1:0]  trap_cause;
    int checks = 0, failures = 0;

    seq_ctrl dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .pc(pc), .branch(branch), .jump(jump),
        .reg_wen_dec(reg_wen_dec), .alu_zero(alu_zero), .target_pc(target_pc), .reg_wen(reg_wen),
        .stage(stage), .halt_req(halt_req), .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        checks++; if (stage !== 3'd0) begin failures++; $display("FAIL rst_stage got=%0d exp=0", stage); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", pc); end
        checks++; if (inst !== 32'h0000_0013) begin failures++; $display("FAIL rst_inst got=%h exp=00000013", inst); end
        checks++; if (instret !== 32'h0 || trap_cause !== 2'd0) begin failures++; $display("FAIL rst_cnt got=%h/%0d exp=0/0", instret, trap_cause); end
        checks++; if ({imem_req, reg_wen, halted, trap, retire} !== 5'b0) begin failures++; $display("FAIL rst_bits got=%b exp=00000", {imem_req, reg_wen, halted, trap, retire}); end
        rst = 0;
    endtask

    task automatic test_zero_wait();
        branch = 0; jump = 0; alu_zero = 0; reg_wen_dec = 1; target_pc = 0;
        tick();
        checks++; if (stage !== 3'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL zw_fetch got=%0d/%b/%h exp=1/1/0", stage, imem_req, imem_addr); end
        imem_ack = 1; imem_rdata = 32'h0050_0093;
        tick();
        imem_ack = 0;
        checks++; if (stage !== 3'd2 || inst !== 32'h0050_0093) begin failures++; $display("FAIL zw_decode got=%0d/%h exp=2/00500093", stage, inst); end
        checks++; if (reg_wen !== 1'b0) begin failures++; $display("FAIL zw_wen_c2 got=%b exp=0", reg_wen); end
        tick();
        checks++; if (stage !== 3'd3 || reg_wen !== 1'b0) begin failures++; $display("FAIL zw_exec got=%0d/%b exp=3/0", stage, reg_wen); end
        tick();
        checks++; if (stage !== 3'd4 || reg_wen !== 1'b1 || retire !== 1'b1) begin failures++; $display("FAIL zw_wb got=%0d/%b/%b exp=4/1/1", stage, reg_wen, retire); end
        tick();
        checks++; if (pc !== 32'h4 || instret !== 32'd1 || stage !== 3'd1) begin failures++; $display("FAIL zw_c5 got=%h/%0d/%0d exp=4/1/1", pc, instret, stage); end
        checks++; if (reg_wen !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL zw_c5_bits got=%b/%b exp=0/0", reg_wen, retire); end
    endtask

    task automatic test_wait_states();
        logic [2:0] exp_stage [1:8] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
        int pulses = 0;
        reg_wen_dec = 0; imem_rdata = 32'h0020_8133;
        for (int c = 1; c <= 8; c++) begin
            checks++; if (stage !== exp_stage[c]) begin failures++; $display("FAIL ws_stage_c%0d got=%0d exp=%0d", c, stage, exp_stage[c]); end
            if (c <= 4) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin failures++; $display("FAIL ws_addr_c%0d got=%b/%h exp=1/4", c, imem_req, imem_addr); end
            end
            checks++; if (retire !== (c == 7)) begin failures++; $display("FAIL ws_retire_c%0d got=%b exp=%b", c, retire, c == 7); end
            pulses += int'(retire);
            imem_ack = (c == 4);
            if (c < 8) tick();
        end
        imem_ack = 0;
        checks++; if (pulses != 1) begin failures++; $display("FAIL ws_pulses got=%0d exp=1", pulses); end
        checks++; if (pc !== 32'h8 || instret !== 32'd2) begin failures++; $display("FAIL ws_end got=%h/%0d exp=8/2", pc, instret); end
    endtask

    task automatic test_branch();
        logic        v_br [3] = '{1'b1, 1'b1, 1'b0};
        logic        v_jp [3] = '{1'b0, 1'b0, 1'b1};
        logic        v_az [3] = '{1'b0, 1'b1, 1'b0};
        logic        v_wen[3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] v_tgt[3] = '{32'h40, 32'h80, 32'h100};
        logic [31:0] v_pc [3] = '{32'h40, 32'h44, 32'h100};
        for (int v = 0; v < 3; v++) begin
            branch = v_br[v]; jump = v_jp[v]; alu_zero = v_az[v]; reg_wen_dec = v_wen[v]; target_pc = v_tgt[v];
            imem_ack = 1; imem_rdata = 32'h0000_1063 + v;
            tick();
            imem_ack = 0;
            tick();
            tick();
            checks++; if (reg_wen !== v_wen[v] || retire !== 1'b1) begin failures++; $display("FAIL br%0d_wb got=%b/%b exp=%b/1", v, reg_wen, retire, v_wen[v]); end
            tick();
            checks++; if (pc !== v_pc[v] || stage !== 3'd1) begin failures++; $display("FAIL br%0d_pc got=%h/%0d exp=%h/1", v, pc, stage, v_pc[v]); end
        end
        checks++; if (instret !== 32'd5) begin failures++; $display("FAIL br_instret got=%0d exp=5", instret); end
        branch = 0; jump = 0; alu_zero = 0; reg_wen_dec = 0;
    endtask

    task automatic test_halt();
        imem_ack = 1; imem_rdata = 32'h0000_0033;
        tick();
        imem_ack = 0;
        tick();
        halt_req = 1;
        tick();
        checks++; if (stage !== 3'd4 || retire !== 1'b1) begin failures++; $display("FAIL halt_wb got=%0d/%b exp=4/1", stage, retire); end
        tick();
        checks++; if (stage !== 3'd5 || halted !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL halt_enter got=%0d/%b/%b exp=5/1/0", stage, halted, imem_req); end
        checks++; if (pc !== 32'h104 || instret !== 32'd6) begin failures++; $display("FAIL halt_pc got=%h/%0d exp=104/6", pc, instret); end
        imem_ack = 1; imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_ack = 0;
        checks++; if (stage !== 3'd5 || inst !== 32'h0000_0033) begin failures++; $display("FAIL halt_ack_ign got=%0d/%h exp=5/00000033", stage, inst); end
        halt_req = 0;
        tick();
        checks++; if (stage !== 3'd1 || imem_addr !== 32'h104 || halted !== 1'b0) begin failures++; $display("FAIL halt_exit got=%0d/%h/%b exp=1/104/0", stage, imem_addr, halted); end
    endtask

    task automatic test_misaligned();
        jump = 1; target_pc = 32'h102; reg_wen_dec = 1;
        imem_ack = 1; imem_rdata = 32'h0020_006F;
        tick();
        imem_ack = 0;
        tick();
        tick();
        checks++; if (stage !== 3'd4 || reg_wen !== 1'b0 || retire !== 1'b0) begin failures++; $display("FAIL mis_wb got=%0d/%b/%b exp=4/0/0", stage, reg_wen, retire); end
        halt_req = 1;
        tick();
        checks++; if (stage !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd2) begin failures++; $display("FAIL mis_trap got=%0d/%b/%0d exp=6/1/2", stage, trap, trap_cause); end
        checks++; if (pc !== 32'h104 || instret !== 32'd6 || reg_wen !== 1'b0) begin failures++; $display("FAIL mis_frozen got=%h/%0d/%b exp=104/6/0", pc, instret, reg_wen); end
        tick();
        tick();
        checks++; if (stage !== 3'd6 || halted !== 1'b0 || trap_cause !== 2'd2) begin failures++; $display("FAIL mis_hold got=%0d/%b/%0d exp=6/0/2", stage, halted, trap_cause); end
        halt_req = 0; jump = 0; reg_wen_dec = 0; rst = 1;
        tick();
        rst = 0;
        checks++; if (stage !== 3'd0 || pc !== 32'h0 || trap !== 1'b0 || trap_cause !== 2'd0) begin failures++; $display("FAIL mis_rst got=%0d/%h/%b/%0d exp=0/0/0/0", stage, pc, trap, trap_cause); end
    endtask

    task automatic test_timeout();
        tick();
        for (int k = 1; k <= 16; k++) begin
            checks++; if (stage !== 3'd1) begin failures++; $display("FAIL to_fetch_c%0d got=%0d exp=1", k, stage); end
            tick();
        end
        checks++; if (stage !== 3'd6 || trap !== 1'b1 || trap_cause !== 2'd1) begin failures++; $display("FAIL to_trap got=%0d/%b/%0d exp=6/1/1", stage, trap, trap_cause); end
        imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 0;
        checks++; if (inst !== 32'h0000_0013 || stage !== 3'd6 || pc !== 32'h0) begin failures++; $display("FAIL to_late_ack got=%h/%0d/%h exp=00000013/6/0", inst, stage, pc); end
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset_mid_fetch();
        reg_wen_dec = 1;
        tick();
        imem_ack = 1; imem_rdata = 32'h0010_0093;
        tick();
        imem_ack = 0;
        tick();
        tick();
        tick();
        checks++; if (instret !== 32'd1 || pc !== 32'h4) begin failures++; $display("FAIL rmf_pre got=%0d/%h exp=1/4", instret, pc); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        checks++; if (imem_req !== 1'b0 || stage !== 3'd0 || pc !== 32'h0 || instret !== 32'd0) begin failures++; $display("FAIL rmf_rst got=%b/%0d/%h/%0d exp=0/0/0/0", imem_req, stage, pc, instret); end
        imem_ack = 1; imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_ack = 0;
        checks++; if (stage !== 3'd1 || inst !== 32'h0000_0013) begin failures++; $display("FAIL rmf_stale_ack got=%0d/%h exp=1/00000013", stage, inst); end
        imem_ack = 1; imem_rdata = 32'h1234_5678;
        tick();
        imem_ack = 0;
        checks++; if (stage !== 3'd2 || inst !== 32'h1234_5678) begin failures++; $display("FAIL rmf_new_fetch got=%0d/%h exp=2/12345678", stage, inst); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch();
        test_halt();
        test_misaligned();
        test_timeout();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
